// File: rtl/reg_file_pkg.sv
// Shared definitions for the parameterised register file.
// Holds the controller state encoding, the default geometry and a
// helper that turns an address width into an entry count.
package reg_file_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  function automatic int unsigned rf_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_init_ctrl.sv
// Clear-sequence controller for reg_file_param.
// After reset it walks every entry once, issuing one clear per edge,
// then sits in RUN with ready high until the next reset.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, restarts the walk at entry 0
//   ready    : clear finished, accesses accepted
//   clr_en   : clear mem[clr_addr] at this edge
//   clr_addr : entry being cleared
module reg_file_init_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    clr_en    = 1'b0;
    clr_addr  = cnt;
    unique case (state)
      ST_INIT: begin
        // A reset edge never clears: the walk starts on the first edge with rst low.
        clr_en  = !rst;
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

endmodule

// File: rtl/reg_file_param.sv
// Parameterised two-read, one-write register file with registered reads.
// Storage is cleared by a sequencer after reset; accesses are accepted
// only once ready is high. A same-edge write to a read address is
// forwarded into the read data (write-first). With ZERO_R0=1 entry 0
// always reads zero and ignores writes.
//   clk, rst       : clock and synchronous active-high reset
//   data_in, rd, WE: write data, write address, write enable
//   RS1, RS2, read : read addresses and common read request
//   num1, num2     : registered read data
//   rvalid         : num1/num2 were loaded by the previous edge
//   ready          : clear finished, accesses accepted
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rd,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  input  logic              read,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic              rvalid,
  output logic              ready
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rdata1, rdata2;

  reg_file_init_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  always_comb begin
    wr_ok = ready && WE && !(ZERO_R0 && (rd == '0));
    rd_ok = ready && read;
  end

  always_comb begin
    rdata1 = mem[RS1];
    if (ZERO_R0 && (RS1 == '0)) begin
      rdata1 = '0;
    end else if (wr_ok && (rd == RS1)) begin
      rdata1 = data_in;
    end
  end

  always_comb begin
    rdata2 = mem[RS2];
    if (ZERO_R0 && (RS2 == '0)) begin
      rdata2 = '0;
    end else if (wr_ok && (rd == RS2)) begin
      rdata2 = data_in;
    end
  end

  // Storage has no reset of its own; the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) begin
        mem[clr_addr] <= '0;
      end else if (wr_ok) begin
        mem[rd] <= data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num1   <= '0;
      num2   <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) begin
        num1 <= rdata1;
        num2 <= rdata2;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [4:0]  rd;
  logic        WE;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic        read;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        rvalid;
  logic        ready;

  int checks;
  int errors;

  reg_file_param #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .ZERO_R0 (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .rd      (rd),
    .WE      (WE),
    .RS1     (RS1),
    .RS2     (RS2),
    .read    (read),
    .num1    (num1),
    .num2    (num2),
    .rvalid  (rvalid),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE   = 1'b0;
    read = 1'b0;
    rd   = '0;
    RS1  = '0;
    RS2  = '0;
    data_in = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready); end
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b want 0", rvalid); end
    checks++;
    if (num1 !== 32'h0 || num2 !== 32'h0) begin
      errors++; $display("FAIL reset_num got %h/%h want 0/0", num1, num2);
    end
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (ready !== (i == 32)) begin
        errors++; $display("FAIL init_ready edge %0d got %0b want %0b", i, ready, (i == 32));
      end
    end
    for (int unsigned a = 0; a < 32; a++) begin
      read = 1'b1;
      RS1  = a[4:0];
      RS2  = 5'(31 - a);
      step();
      checks++;
      if (num1 !== 32'h0 || num2 !== 32'h0 || rvalid !== 1'b1) begin
        errors++; $display("FAIL init_clear addr %0d got %h/%h rvalid %0b want 0/0 rvalid 1", a, num1, num2, rvalid);
      end
    end
    idle();
    step();
  endtask

  task automatic test_write_read();
    WE = 1'b1; rd = 5'd7; data_in = 32'hDEADBEEF;
    step();
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid got %0b want 0", rvalid); end
    idle();
    read = 1'b1; RS1 = 5'd7; RS2 = 5'd6;
    step();
    checks++;
    if (num1 !== 32'hDEADBEEF || rvalid !== 1'b1) begin
      errors++; $display("FAIL rd7 got %h rvalid %0b want deadbeef rvalid 1", num1, rvalid);
    end
    checks++;
    if (num2 !== 32'h0) begin errors++; $display("FAIL rd6 got %h want 0", num2); end
    idle();
    RS1 = 5'd6;
    step();
    checks++;
    if (num1 !== 32'hDEADBEEF || rvalid !== 1'b0) begin
      errors++; $display("FAIL hold got %h rvalid %0b want deadbeef rvalid 0", num1, rvalid);
    end
  endtask

  task automatic test_bypass();
    WE = 1'b1; rd = 5'd4; data_in = 32'h44;
    step();
    WE = 1'b1; rd = 5'd3; data_in = 32'h55;
    read = 1'b1; RS1 = 5'd3; RS2 = 5'd4;
    step();
    checks++;
    if (num1 !== 32'h55 || num2 !== 32'h44) begin
      errors++; $display("FAIL bypass got %h/%h want 55/44", num1, num2);
    end
    idle();
    read = 1'b1; RS1 = 5'd4; RS2 = 5'd3;
    step();
    checks++;
    if (num1 !== 32'h44 || num2 !== 32'h55) begin
      errors++; $display("FAIL bypass_stored got %h/%h want 44/55", num1, num2);
    end
    idle();
  endtask

  task automatic test_same_addr();
    read = 1'b1; RS1 = 5'd7; RS2 = 5'd7;
    step();
    checks++;
    if (num1 !== 32'hDEADBEEF || num2 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL same_addr got %h/%h want deadbeef/deadbeef", num1, num2);
    end
    WE = 1'b1; rd = 5'd31; data_in = 32'h80000001;
    read = 1'b0;
    step();
    idle();
    read = 1'b1; RS1 = 5'd30; RS2 = 5'd31;
    step();
    checks++;
    if (num1 !== 32'h0 || num2 !== 32'h80000001) begin
      errors++; $display("FAIL top_entry got %h/%h want 0/80000001", num1, num2);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    WE = 1'b1; rd = 5'd0; data_in = 32'hFFFFFFFF;
    read = 1'b1; RS1 = 5'd0; RS2 = 5'd0;
    step();
    checks++;
    if (num1 !== 32'h0 || num2 !== 32'h0) begin
      errors++; $display("FAIL zero_bypass got %h/%h want 0/0", num1, num2);
    end
    idle();
    read = 1'b1; RS1 = 5'd0; RS2 = 5'd7;
    step();
    checks++;
    if (num1 !== 32'h0 || num2 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL zero_later got %h/%h want 0/deadbeef", num1, num2);
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    WE = 1'b1; rd = 5'd9; data_in = 32'h12;
    step();
    read = 1'b1; RS1 = 5'd9; WE = 1'b0;
    step();
    checks++;
    if (num1 !== 32'h12) begin errors++; $display("FAIL pre_rst9 got %h want 12", num1); end
    // Reset edge carries a write that must be dropped.
    rst = 1'b1; WE = 1'b1; rd = 5'd10; data_in = 32'h34; read = 1'b1;
    step();
    checks++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || num1 !== 32'h0) begin
      errors++; $display("FAIL midrun_rst got ready %0b rvalid %0b num1 %h want 0 0 0", ready, rvalid, num1);
    end
    rst = 1'b0;
    WE = 1'b1; rd = 5'd5; data_in = 32'h99; read = 1'b1; RS1 = 5'd9;
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (ready !== (i == 32) || (i < 32 && rvalid !== 1'b0)) begin
        errors++; $display("FAIL gate edge %0d got ready %0b rvalid %0b", i, ready, rvalid);
      end
    end
    idle();
    read = 1'b1; RS1 = 5'd9; RS2 = 5'd5;
    step();
    checks++;
    if (num1 !== 32'h0 || num2 !== 32'h0 || rvalid !== 1'b1) begin
      errors++; $display("FAIL post_rst got %h/%h rvalid %0b want 0/0 rvalid 1", num1, num2, rvalid);
    end
    read = 1'b1; RS1 = 5'd10;
    step();
    checks++;
    if (num1 !== 32'h0) begin errors++; $display("FAIL rst_write_drop got %h want 0", num1); end
    WE = 1'b1; rd = 5'd5; data_in = 32'hA5; read = 1'b0;
    step();
    idle();
    read = 1'b1; RS1 = 5'd5;
    step();
    read = 1'b0; RS1 = 5'd9;
    step();
    checks++;
    if (num1 !== 32'hA5 || rvalid !== 1'b0) begin
      errors++; $display("FAIL hold_after got %h rvalid %0b want a5 rvalid 0", num1, rvalid);
    end
  endtask

  task automatic test_reset_mid_init();
    WE = 1'b1; rd = 5'd12; data_in = 32'h77;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i >= 31) begin
        checks++;
        if (ready !== (i == 32)) begin
          errors++; $display("FAIL midinit edge %0d got %0b want %0b", i, ready, (i == 32));
        end
      end
    end
    read = 1'b1; RS1 = 5'd12; RS2 = 5'd31;
    step();
    checks++;
    if (num1 !== 32'h0 || num2 !== 32'h0) begin
      errors++; $display("FAIL midinit_clear got %h/%h want 0/0", num1, num2);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_same_addr();
    test_zero_reg();
    test_reset_mid_run();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter ZERO_R0, default 1, meaning 1 forces entry 0 to read as zero and ignore writes.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-005 SHALL provide port clk, input, 1 bit, meaning rising-edge clock for all state.
REQ-006 SHALL provide port rst, input, 1 bit, meaning synchronous active-high reset that starts the clear sequence.
REQ-007 SHALL provide port data_in, input, DATA_W bits, meaning write data.
REQ-008 SHALL provide port rd, input, ADDR_W bits, meaning write address.
REQ-009 SHALL provide port WE, input, 1 bit, meaning write enable.
REQ-010 SHALL provide port RS1, input, ADDR_W bits, meaning read address, port 1.
REQ-011 SHALL provide port RS2, input, ADDR_W bits, meaning read address, port 2.
REQ-012 SHALL provide port read, input, 1 bit, meaning read request for both ports.
REQ-013 SHALL provide port num1, output, DATA_W bits, meaning registered read data, port 1.
REQ-014 SHALL provide port num2, output, DATA_W bits, meaning registered read data, port 2.
REQ-015 SHALL provide port rvalid, output, 1 bit, meaning num1/num2 updated by the previous edge's accepted read.
REQ-016 SHALL provide port ready, output, 1 bit, meaning clear sequence complete and accesses accepted.

Function
REQ-017 SHALL implement two FSM states: INIT (clearing) and RUN.
REQ-018 In INIT with rst low, each edge SHALL write 0 to mem[cnt] and increment cnt.
REQ-019 The edge that clears entry DEPTH-1 SHALL move the FSM to RUN.
REQ-020 ready SHALL go high exactly DEPTH edges after the first edge with rst low.
REQ-021 In INIT, WE and read SHALL be ignored, and rvalid SHALL stay 0.
REQ-022 In RUN, a read (read=1 at an edge) SHALL register num1/num2 from RS1/RS2 at that edge, with 1-cycle latency, and SHALL set rvalid=1 for one cycle.
REQ-023 In RUN, when read=0, num1/num2 SHALL hold their values and rvalid SHALL be 0.
REQ-024 In RUN, WE=1 SHALL write data_in to mem[rd] at the edge.
REQ-025 Write-first bypass: if WE=1 and rd==RSx (rd nonzero or ZERO_R0=0) on the same edge as a read, numx SHALL capture data_in.
REQ-026 With ZERO_R0=1, reads of address 0 SHALL return 0, and writes to 0 SHALL be discarded, including via bypass.
REQ-027 RS1==RS2 SHALL return identical data on both ports.
REQ-028 Reads and writes SHALL be full-width with no sign handling; addresses SHALL cover all DEPTH entries with no wrap.

Reset
REQ-029 At a rst edge, the block SHALL set FSM=INIT, cnt=0, num1=0, num2=0, rvalid=0, and ready=0.
REQ-030 rst asserted mid-INIT or mid-RUN SHALL restart the clear from entry 0, and any write on that edge SHALL be dropped.
REQ-031 After the clear completes, every entry SHALL read 0.

Structure
REQ-032 Package reg_file_pkg SHALL hold the FSM state enum, the default DATA_W/ADDR_W constants, and a DEPTH helper function.
REQ-033 The FSM plus clear counter SHALL be one sub-module, reg_file_init_ctrl, outputting ready, clr_en and clr_addr.
REQ-034 Storage and bypass/read logic SHALL stay in reg_file_param.

Verification
REQ-035 Init: rst for 2 cycles then low, default params -> ready=0 for 31 edges, ready=1 after the 32nd edge; reads of 0..31 all return 0.
REQ-036 Write/read: WE, rd=7, data_in=0xDEADBEEF; next cycle read with RS1=7 -> num1=0xDEADBEEF and rvalid=1 one cycle later.
REQ-037 Bypass: on the same edge WE, rd=3, data_in=0x55 and read, RS1=3, RS2=4 (holding 0x44) -> num1=0x55, num2=0x44.
REQ-038 Zero reg: WE, rd=0, data_in=0xFFFFFFFF with a simultaneous read RS1=0 -> num1=0; a later read RS1=0 -> 0.
REQ-039 Reset mid-op: write 0x12 to entry 9, assert rst in RUN -> ready drops, and after 32 edges reading RS1=9 gives 0.
REQ-040 Gating: WE with rd=5, data_in=0x99 during INIT -> once ready, reading RS1=5 gives 0; with read=0, num1 holds and rvalid=0.
